// File: rtl/rng_pkg.sv
// Shared types and constants for the random-number grant controller.
package rng_pkg;

  localparam int LFSR_W = 64;

  // All-ones is the fixed point of an XNOR-feedback LFSR.
  localparam logic [LFSR_W-1:0] LFSR_LOCKUP = {LFSR_W{1'b1}};

  typedef enum logic [1:0] {
    S_LOAD,
    S_WARM,
    S_READY,
    S_GAP
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: combinational one-hot choice from req_i starting at
// the stored pointer; the pointer moves past the winner only when en_i
// confirms the grant was actually issued.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               any_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] win;
  logic          found;

  // First asserted request at or above the pointer, wrapping past the top.
  always_comb begin
    int idx;
    gnt_o = '0;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        win        = PW'(idx);
      end
    end
  end

  assign any_o = found;

  // Pointer advances to one past the winner, only on an issued grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (en_i && found) begin
      ptr_q <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/rng_grant_ctrl.sv
// Seeds, warms up and shares an external 64-bit XNOR LFSR among NUM_REQ
// requesters, one word per grant, round-robin, with a minimum shift gap
// between grants. Optional macro RNG_LOCKUP_DETECT_EN adds all-ones
// lock-up detection/recovery and the sticky lockup_err flag.
module rng_grant_ctrl
  import rng_pkg::*;
#(
  parameter int                NUM_REQ       = 4,
  parameter int                WARMUP_CYCLES = 8,
  parameter int                GAP_CYCLES    = 4,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED  = 64'h0000_0000_0000_0001
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [LFSR_W-1:0]  rnd_data,
  output logic               rnd_valid,
  input  logic [LFSR_W-1:0]  seed_in,
  input  logic               seed_load,
  output logic               seed_busy,
  output logic [LFSR_W-1:0]  lfsr_seed,
  output logic               lfsr_load,
  input  logic [LFSR_W-1:0]  lfsr_value,
  output logic               lockup_err
);

  localparam int CNT_MAX = max2(WARMUP_CYCLES, GAP_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [LFSR_W-1:0]  rnd_data_q;
  logic               rnd_valid_q;
  logic               busy_q;
  logic [LFSR_W-1:0]  lfsr_seed_q;
  logic               lfsr_load_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic               arb_any;
  logic               arb_en;
  logic               lock_hit;
  logic [LFSR_W-1:0]  seed_sel;

`ifdef RNG_LOCKUP_DETECT_EN
  logic bad_seed;
  logic err_q;

  assign bad_seed = (seed_in == LFSR_LOCKUP);
  assign lock_hit = ((state_q == S_READY) || (state_q == S_GAP)) &&
                    (lfsr_value == LFSR_LOCKUP);
  assign seed_sel = bad_seed ? DEFAULT_SEED : seed_in;

  // Sticky lock-up flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (lock_hit || (seed_load && bad_seed)) begin
      err_q <= 1'b1;
    end
  end

  assign lockup_err = err_q;
`else
  assign lock_hit   = 1'b0;
  assign seed_sel   = seed_in;
  assign lockup_err = 1'b0;
`endif

  // A grant is only committed from S_READY when no reseed/recovery preempts it.
  assign arb_en = (state_q == S_READY) && !seed_load && !lock_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req),
    .en_i  (arb_en),
    .gnt_o (arb_gnt),
    .any_o (arb_any)
  );

  // Sequencer: load -> warm-up -> ready <-> gap, with reseed from anywhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rnd_data_q  <= '0;
      rnd_valid_q <= 1'b0;
      busy_q      <= 1'b1;
      lfsr_seed_q <= DEFAULT_SEED;
      lfsr_load_q <= 1'b1;
    end else begin
      gnt_q       <= '0;
      rnd_data_q  <= '0;
      rnd_valid_q <= 1'b0;
      lfsr_load_q <= 1'b0;
      if (seed_load) begin
        state_q     <= S_LOAD;
        busy_q      <= 1'b1;
        lfsr_seed_q <= seed_sel;
        lfsr_load_q <= 1'b1;
      end else if (lock_hit) begin
        state_q     <= S_LOAD;
        busy_q      <= 1'b1;
        lfsr_seed_q <= DEFAULT_SEED;
        lfsr_load_q <= 1'b1;
      end else begin
        case (state_q)
          S_LOAD: begin
            state_q <= S_WARM;
            cnt_q   <= CW'(WARMUP_CYCLES - 1);
          end
          S_WARM: begin
            if (cnt_q == '0) begin
              state_q <= S_READY;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          S_READY: begin
            if (arb_any) begin
              gnt_q       <= arb_gnt;
              rnd_data_q  <= lfsr_value;
              rnd_valid_q <= 1'b1;
              state_q     <= S_GAP;
              cnt_q       <= CW'(GAP_CYCLES - 1);
            end
          end
          S_GAP: begin
            if (cnt_q == '0) begin
              state_q <= S_READY;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: state_q <= S_LOAD;
        endcase
      end
    end
  end

  assign gnt       = gnt_q;
  assign rnd_data  = rnd_data_q;
  assign rnd_valid = rnd_valid_q;
  assign seed_busy = busy_q;
  assign lfsr_seed = lfsr_seed_q;
  assign lfsr_load = lfsr_load_q;

endmodule

// File: tb/tb_rng_grant_ctrl.sv
// Bench for rng_grant_ctrl: stands in for the lfsr64 instance, runs directed
// scenarios plus random traffic, and compares every cycle against a
// schedule-based model (load time, ready time, pointer, seed).
module tb_rng_grant_ctrl;

  localparam int          NREQ = 4;
  localparam int          WARM = 8;
  localparam int          GAP  = 4;
  localparam logic [63:0] DEF  = 64'h0000_0000_0000_0001;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [63:0]     rnd_data;
  logic            rnd_valid;
  logic [63:0]     seed_in;
  logic            seed_load;
  logic            seed_busy;
  logic [63:0]     lfsr_seed;
  logic            lfsr_load;
  logic [63:0]     lfsr_value;
  logic            lockup_err;

  int nvec = 0;
  int nerr = 0;

  // model state
  int              m_t, m_load_t, m_ready_t, m_ptr;
  logic [63:0]     m_seed, m_data;
  logic [NREQ-1:0] m_gnt;
  logic            m_err;

  rng_grant_ctrl #(
    .NUM_REQ       (NREQ),
    .WARMUP_CYCLES (WARM),
    .GAP_CYCLES    (GAP),
    .DEFAULT_SEED  (DEF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .gnt        (gnt),
    .rnd_data   (rnd_data),
    .rnd_valid  (rnd_valid),
    .seed_in    (seed_in),
    .seed_load  (seed_load),
    .seed_busy  (seed_busy),
    .lfsr_seed  (lfsr_seed),
    .lfsr_load  (lfsr_load),
    .lfsr_value (lfsr_value),
    .lockup_err (lockup_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] lfsr_step(input logic [63:0] v);
    return {v[62:0], ~(v[63] ^ v[62] ^ v[60] ^ v[59])};
  endfunction

  function automatic logic [63:0] lfsr_adv(input logic [63:0] s, input int n);
    logic [63:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = lfsr_step(v);
    return v;
  endfunction

  // lfsr64 stand-in: load when asked, otherwise shift every clock.
  always_ff @(posedge clk)
    lfsr_value <= lfsr_load ? lfsr_seed : lfsr_step(lfsr_value);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %h want %h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_t       = 0;
    m_load_t  = 0;
    m_ready_t = WARM + 1;
    m_ptr     = 0;
    m_seed    = DEF;
    m_gnt     = '0;
    m_data    = '0;
    m_err     = 1'b0;
  endtask

  // Advance the model over the clock edge that just closed cycle m_t.
  task automatic model_step();
    int w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_gnt  = '0;
    m_data = '0;
    if (seed_load) begin
      m_load_t  = m_t + 1;
      m_ready_t = m_t + 2 + WARM;
      m_seed    = seed_in;
`ifdef RNG_LOCKUP_DETECT_EN
      if (seed_in == ONES) begin
        m_seed = DEF;
        m_err  = 1'b1;
      end
`endif
    end else if (m_t >= m_ready_t && req != '0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      m_gnt[w]  = 1'b1;
      m_data    = lfsr_adv(m_seed, m_t - m_load_t - 1);
      m_ptr     = (w + 1) % NREQ;
      m_ready_t = m_t + GAP + 1;
    end
    m_t++;
  endtask

  task automatic check_all();
    chk("gnt", gnt, m_gnt);
    chk("rnd_valid", rnd_valid, |m_gnt);
    chk("rnd_data", rnd_data, m_data);
    chk("seed_busy", seed_busy, (m_t < m_load_t + WARM + 1));
    chk("lfsr_load", lfsr_load, (m_t == m_load_t));
    if (m_t == m_load_t) chk("lfsr_seed", lfsr_seed, m_seed);
    chk("lockup_err", lockup_err, m_err);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_gnt(input string tag, input int max_cyc);
    int seen;
    seen = 0;
    for (int i = 0; i < max_cyc; i++) begin
      cycle();
      if (gnt != '0) begin
        seen = 1;
        break;
      end
    end
    chk(tag, seen, 1);
  endtask

  initial begin
    int          t_ref, t_prev;
    logic [63:0] s2;
    rst_n     = 1'b0;
    req       = '0;
    seed_load = 1'b0;
    seed_in   = '0;
    repeat (3) cycle();

    // first grant after reset: load + warm-up, data from seed 1
    req   = 4'b0001;
    rst_n = 1'b1;
    wait_gnt("t1_wait", 40);
    chk("t1_latency", m_t, 10);
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_data", rnd_data, lfsr_adv(DEF, WARM));

    // round-robin with all requesting, from a fresh pointer
    rst_n = 1'b0;
    repeat (2) cycle();
    req   = 4'b1111;
    rst_n = 1'b1;
    wait_gnt("t2_wait0", 40);
    chk("t2_first", gnt, 4'b0001);
    t_prev = m_t;
    for (int k = 1; k <= 4; k++) begin
      wait_gnt("t2_wait", 10);
      chk("t2_order", gnt, 4'b0001 << (k % 4));
      chk("t2_spacing", m_t - t_prev, GAP + 1);
      t_prev = m_t;
    end

    // reseed wins over a grant in S_READY
    req = '0;
    repeat (8) cycle();
    req       = 4'b0100;
    seed_in   = 64'hDEAD_BEEF_0000_1234;
    seed_load = 1'b1;
    t_ref     = m_t;
    cycle();
    seed_load = 1'b0;
    cycle();
    chk("t3_nognt", gnt, 4'b0000);
    chk("t3_busy", seed_busy, 1'b1);
    wait_gnt("t3_wait", 20);
    chk("t3_gnt", gnt, 4'b0100);
    chk("t3_latency", m_t - t_ref, WARM + 3);
    chk("t3_data", rnd_data, lfsr_adv(64'hDEAD_BEEF_0000_1234, WARM));

    // reseed in the middle of warm-up restarts it
    req       = '0;
    seed_in   = {$urandom, $urandom};
    seed_load = 1'b1;
    cycle();
    seed_load = 1'b0;
    repeat (5) cycle();
    s2        = {$urandom, $urandom} | 64'h1;
    seed_in   = s2;
    seed_load = 1'b1;
    req       = 4'b0001;
    t_ref     = m_t;
    cycle();
    seed_load = 1'b0;
    wait_gnt("t4_wait", 20);
    chk("t4_latency", m_t - t_ref, WARM + 3);
    chk("t4_data", rnd_data, lfsr_adv(s2, WARM));

    // random traffic with occasional reseeds
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && !gnt[i]) req[i] = ($urandom_range(0, 99) >= 3);
        else                   req[i] = ($urandom_range(0, 99) < 30);
      end
      seed_load = ($urandom_range(0, 149) == 0);
      seed_in   = {$urandom, $urandom};
      cycle();
    end

    // async reset mid-gap clears outputs and the pointer
    req       = 4'b1010;
    seed_load = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 60; i++) begin
        cycle();
        if (gnt == 4'b0010) begin
          seen = 1;
          break;
        end
      end
      chk("t6_wait", seen, 1);
    end
    @(posedge clk);
    model_step();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_gnt_clr", gnt, 4'b0000);
    chk("t6_vld_clr", rnd_valid, 1'b0);
    chk("t6_busy_rst", seed_busy, 1'b1);
    @(negedge clk);
    check_all();
    repeat (2) cycle();
    rst_n = 1'b1;
    wait_gnt("t6_wait2", 40);
    chk("t6_gnt", gnt, 4'b0010);
    chk("t6_latency", m_t, 10);

    // all-ones seed
    req       = 4'b0001;
    seed_in   = ONES;
    seed_load = 1'b1;
    cycle();
    seed_load = 1'b0;
    wait_gnt("t7_wait", 30);
`ifdef RNG_LOCKUP_DETECT_EN
    chk("t7_data", rnd_data, lfsr_adv(DEF, WARM));
    chk("t7_err", lockup_err, 1'b1);
`else
    chk("t7_data", rnd_data, ONES);
    chk("t7_err", lockup_err, 1'b0);
`endif
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
